// File: rtl/sobel_window_buffer_pkg.sv
// Shared constants for the Sobel 3x3 window buffer: pixel width and window slot indices.
// Slot k = 3*r + c, where r=0 is the oldest row and c=0 is the leftmost column.
package sobel_window_buffer_pkg;

  localparam int PIX_W = 8;
  localparam int WIN_N = 9;
  localparam int WIN_W = WIN_N * PIX_W;

  localparam int P0 = 0;
  localparam int P1 = 1;
  localparam int P2 = 2;
  localparam int P3 = 3;
  localparam int P4 = 4;
  localparam int P5 = 5;
  localparam int P6 = 6;
  localparam int P7 = 7;
  localparam int P8 = 8;

  function automatic int win_idx(input int r, input int c);
    return 3 * r + c;
  endfunction

endpackage

// File: rtl/sobel_window_buffer_if.sv
// Pixel stream in (from the loader counter) and 3x3 window stream out (to the gradient stage).
// The master drives pixels and coordinates; the slave is the window buffer.
interface sobel_window_buffer_if #(
  parameter int NumOfBit = 8
);
  import sobel_window_buffer_pkg::*;

  logic                 Enable;
  logic [PIX_W-1:0]     Pixel_In;
  logic [NumOfBit-1:0]  In_Row;
  logic [NumOfBit-1:0]  In_Column;
  logic                 Last_In;
  logic [WIN_W-1:0]     Window_Out;
  logic                 Window_Valid;
  logic [NumOfBit-1:0]  Out_Row;
  logic [NumOfBit-1:0]  Out_Column;
  logic                 Frame_Done;

  modport master (
    output Enable, Pixel_In, In_Row, In_Column, Last_In,
    input  Window_Out, Window_Valid, Out_Row, Out_Column, Frame_Done
  );

  modport slave (
    input  Enable, Pixel_In, In_Row, In_Column, Last_In,
    output Window_Out, Window_Valid, Out_Row, Out_Column, Frame_Done
  );

endinterface

// File: rtl/sobel_window_buffer_line_buffer.sv
// One image row of pixels: asynchronous read, synchronous write, so a same-cycle read sees the old word.
// Contents are deliberately not reset; every row is rewritten before it is consumed.
module sobel_line_buffer #(
  parameter int DEPTH = 256,
  parameter int AW    = 8,
  parameter int W     = 8
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [W-1:0]  i_wdat,
  output logic [W-1:0]  o_rdat
);

  logic [W-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdat;
    end
  end

  assign o_rdat = r_mem[i_addr];

endmodule

// File: rtl/sobel_window_buffer.sv
// Two line buffers plus a nine-register sliding window; emits complete interior 3x3 windows.
// One cycle from pixel accept to window; Enable=0 holds all state and drops Window_Valid.
module sobel_window_buffer
  import sobel_window_buffer_pkg::*;
#(
  parameter int NumOfBit = 8,
  parameter int IMG_W    = 256
) (
  input  logic                  CLK,
  input  logic                  Reset,
  sobel_window_buffer_if.slave  bus
);

  logic [PIX_W-1:0]             w_top;
  logic [PIX_W-1:0]             w_mid;
  logic [WIN_N-1:0][PIX_W-1:0]  r_win;
  logic [WIN_N-1:0][PIX_W-1:0]  w_win_nxt;
  logic                         w_win_ok;
  logic                         r_vld;
  logic                         r_done;
  logic [NumOfBit-1:0]          r_row;
  logic [NumOfBit-1:0]          r_col;

  // LB1 holds the previous row, LB2 the one before; LB2 is refilled from LB1's old word.
  sobel_line_buffer #(
    .DEPTH (IMG_W),
    .AW    (NumOfBit),
    .W     (PIX_W)
  ) u_lb1 (
    .i_clk  (CLK),
    .i_we   (bus.Enable),
    .i_addr (bus.In_Column),
    .i_wdat (bus.Pixel_In),
    .o_rdat (w_mid)
  );

  sobel_line_buffer #(
    .DEPTH (IMG_W),
    .AW    (NumOfBit),
    .W     (PIX_W)
  ) u_lb2 (
    .i_clk  (CLK),
    .i_we   (bus.Enable),
    .i_addr (bus.In_Column),
    .i_wdat (w_mid),
    .o_rdat (w_top)
  );

  always_comb begin
    w_win_nxt     = r_win;
    w_win_nxt[P0] = r_win[P1];
    w_win_nxt[P1] = r_win[P2];
    w_win_nxt[P2] = w_top;
    w_win_nxt[P3] = r_win[P4];
    w_win_nxt[P4] = r_win[P5];
    w_win_nxt[P5] = w_mid;
    w_win_nxt[P6] = r_win[P7];
    w_win_nxt[P7] = r_win[P8];
    w_win_nxt[P8] = bus.Pixel_In;
  end

  // Columns 0 and 1 still carry the previous row's tail, so they never form a window.
  assign w_win_ok = bus.Enable
                  && (bus.In_Row    >= NumOfBit'(2))
                  && (bus.In_Column >= NumOfBit'(2));

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_win  <= '0;
      r_vld  <= 1'b0;
      r_done <= 1'b0;
      r_row  <= '0;
      r_col  <= '0;
    end else begin
      r_vld  <= w_win_ok;
      r_done <= bus.Enable & bus.Last_In;
      if (bus.Enable) begin
        r_win <= w_win_nxt;
      end
      if (w_win_ok) begin
        r_row <= bus.In_Row    - NumOfBit'(1);
        r_col <= bus.In_Column - NumOfBit'(1);
      end
    end
  end

  assign bus.Window_Out   = r_win;
  assign bus.Window_Valid = r_vld;
  assign bus.Out_Row      = r_row;
  assign bus.Out_Column   = r_col;
  assign bus.Frame_Done   = r_done;

endmodule

// File: tb/tb_sobel_window_buffer.sv
// Directed bench for sobel_window_buffer on an 8x8 image: raster frames, gaps, back-to-back frames, mid-frame reset.
module tb_sobel_window_buffer;
  import sobel_window_buffer_pkg::*;

  localparam int NB = 3;
  localparam int IW = 8;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  int   n_valid;

  sobel_window_buffer_if #(.NumOfBit(NB)) bus();

  sobel_window_buffer #(
    .NumOfBit (NB),
    .IMG_W    (IW)
  ) dut (
    .CLK   (clk),
    .Reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [71:0] pack9(input int p0, input int p1, input int p2,
                                        input int p3, input int p4, input int p5,
                                        input int p6, input int p7, input int p8);
    logic [71:0] w;
    w = {p8[7:0], p7[7:0], p6[7:0], p5[7:0], p4[7:0], p3[7:0], p2[7:0], p1[7:0], p0[7:0]};
    return w;
  endfunction

  // Expected window whose bottom-right pixel is (r,c) in a frame of value base+8*row+col.
  function automatic logic [71:0] exp_win(input int base, input int r, input int c);
    logic [71:0] w;
    int v;
    w = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        v = base + 8 * (r - 2 + i) + (c - 2 + j);
        w[8*(3*i+j) +: 8] = v[7:0];
      end
    end
    return w;
  endfunction

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, {71'd0, bus.Window_Valid}, 72'd0);
    chk({tag, "_done"},  {71'd0, bus.Frame_Done},   72'd0);
    chk({tag, "_win"},   bus.Window_Out,            72'd0);
    chk({tag, "_row"},   {69'd0, bus.Out_Row},      72'd0);
    chk({tag, "_col"},   {69'd0, bus.Out_Column},   72'd0);
  endtask

  task automatic send(input int base, input int r, input int c, input bit last, input int gap);
    int  pix;
    bit  v;
    pix           = base + 8 * r + c;
    bus.Enable    = 1'b1;
    bus.Pixel_In  = pix[7:0];
    bus.In_Row    = r[NB-1:0];
    bus.In_Column = c[NB-1:0];
    bus.Last_In   = last;
    @(posedge clk);
    #1;
    bus.Enable  = 1'b0;
    bus.Last_In = 1'b0;
    v = (r >= 2) && (c >= 2);
    chk("valid", {71'd0, bus.Window_Valid}, {71'd0, v});
    chk("done",  {71'd0, bus.Frame_Done},   {71'd0, last});
    if (bus.Window_Valid) n_valid++;
    if (v) begin
      chk("win", bus.Window_Out, exp_win(base, r, c));
      chk("out_row", {69'd0, bus.Out_Row},    72'(r - 1));
      chk("out_col", {69'd0, bus.Out_Column}, 72'(c - 1));
    end
    if (base == 0 && r == 2 && c == 2)
      chk("first_win", bus.Window_Out, pack9(0, 1, 2, 8, 9, 10, 16, 17, 18));
    if (base == 0 && r == 3 && c == 2)
      chk("win_3_2", bus.Window_Out, pack9(8, 9, 10, 16, 17, 18, 24, 25, 26));
    if (base == 100 && r == 2 && c == 2)
      chk("f2_first_win", bus.Window_Out, pack9(100, 101, 102, 108, 109, 110, 116, 117, 118));
    if (last)
      chk("last_p4", {64'd0, bus.Window_Out[8*P4 +: 8]}, 72'(base + 54));
    repeat (gap) begin
      @(posedge clk);
      #1;
      chk("idle_valid", {71'd0, bus.Window_Valid}, 72'd0);
      chk("idle_done",  {71'd0, bus.Frame_Done},   72'd0);
      if (v) chk("idle_hold", bus.Window_Out, exp_win(base, r, c));
    end
  endtask

  task automatic run_frame(input int base, input bit gaps);
    int g;
    n_valid = 0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        g = gaps ? int'($urandom_range(1, 5)) : 0;
        send(base, r, c, (r == 7 && c == 7), g);
      end
    end
    chk("n_valid", 72'(n_valid), 72'd36);
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    n_valid       = 0;
    rst_n         = 1'b0;
    bus.Enable    = 1'b0;
    bus.Pixel_In  = '0;
    bus.In_Row    = '0;
    bus.In_Column = '0;
    bus.Last_In   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Gap-free frame, then a back-to-back frame, then a frame with idle gaps.
    run_frame(0, 1'b0);
    run_frame(100, 1'b0);
    run_frame(0, 1'b1);

    // Partial frame up to (4,2), then reset asserted between edges while (4,3) is offered.
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 8; c++) begin
        if (8 * r + c <= 8 * 4 + 2) send(0, r, c, 1'b0, 0);
      end
    end
    chk("pre_rst_valid", {71'd0, bus.Window_Valid}, 72'd1);
    bus.Enable    = 1'b1;
    bus.Pixel_In  = 8'd35;
    bus.In_Row    = 3'd4;
    bus.In_Column = 3'd3;
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("async_rst");
    @(posedge clk);
    #1;
    check_zero("held_rst");
    bus.Enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_frame(0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sobel_window_buffer.md
Name: sobel_window_buffer

Overview:
- Sits directly downstream of the loader's row/column counter.
- Consumes the raster pixel stream plus the counter's row/column addresses and end-of-frame flag.
- Keeps two previous image rows in line buffers and emits a registered 3x3 neighbourhood for the Sobel gradient stage.
- Emits only complete interior windows; no border padding.

Parameters:
- NumOfBit, 8, width of the row/column addresses; must match the loader counter.
- IMG_W, 256, image width in pixels, equal to 2**NumOfBit; line buffer depth.
- PIX_W, 8, pixel width in bits.

Ports:
- CLK  in  1  single clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Enable  in  1  pixel strobe; the pixel and its coordinates are accepted on a rising CLK edge while 1.
- Pixel_In  in  PIX_W  pixel value, raster order.
- In_Row  in  NumOfBit  row of Pixel_In.
- In_Column  in  NumOfBit  column of Pixel_In.
- Last_In  in  1  marks the final pixel of the frame (loader isEnd); sampled only with Enable.
- Window_Out  out  9*PIX_W  P0..P8, Pk at [PIX_W*k +: PIX_W], k=3*r+c; r=0 is the oldest row, c=0 the leftmost column.
- Window_Valid  out  1  Window_Out, Out_Row and Out_Column are valid this cycle.
- Out_Row  out  NumOfBit  row of the window centre (P4).
- Out_Column  out  NumOfBit  column of the window centre (P4).
- Frame_Done  out  1  one-cycle pulse after the last pixel has been accepted.

Behaviour:
- Reset (Reset=0, async): clears Window_Out, Window_Valid, Out_Row, Out_Column, Frame_Done and all nine window registers. Line buffer contents are not reset.
- Accept cycle (Enable=1), with c=In_Column:
  - Read before write: top=LB2[c], mid=LB1[c], bot=Pixel_In.
  - Update LB2[c]<=LB1[c] and LB1[c]<=Pixel_In.
  - Each window row shifts left by one (P0<=P1, P1<=P2, and likewise for the other rows).
  - The new column enters on the right: P2<=top, P5<=mid, P8<=bot.
- Latency: one cycle. The window that includes the pixel accepted at edge N is visible after edge N.
- Window_Valid is registered as Enable & (In_Row>=2) & (In_Column>=2).
- Out_Row is registered as In_Row-1 and Out_Column as In_Column-1.
- When Enable=1 and the window is not complete, Window_Valid=0. Window registers still shift.
- Enable=0: all state holds, Window_Valid<=0, no line buffer write. Gaps of any length are legal.
- Row wrap: at In_Column 0 and 1, stale columns from the previous row are in the window, so Window_Valid=0 there.
- Rows 0 and 1 only fill the line buffers and never assert Window_Valid.
- Valid windows per frame: (IMG_W-2)*(rows-2).
- Frame_Done is registered as Enable & Last_In. It pulses for exactly one cycle, coincident with the final Window_Valid.
- The next frame may start the cycle after Last_In. Line buffers are overwritten before they are read as valid data.
- Reset mid-frame: outputs drop immediately and the partial frame is discarded. The next frame must restart at row 0, column 0.
- Out-of-order coordinates are not checked; the block relies on the loader counter's raster order.
- Arithmetic: coordinate compares and the -1 are unsigned, NumOfBit wide. The -1 cannot underflow because it applies only when the coordinate is >=2.

Decomposition:
- Shared package: PIX_W, the window index constants P0..P8 (k=3*r+c), and the window slice width.
- Sub-module sobel_line_buffer: IMG_W x PIX_W single-port, read-before-write RAM with a write enable.
  - Two instances, LB1 and LB2.
  - Asynchronous read, synchronous write, so the block keeps its one-cycle latency.
- Remaining logic stays in the top: the nine-register window, the valid/coordinate pipeline register and Frame_Done.

Test Plan:
- IMG_W=8, 8x8 frame, Pixel_In=8*row+col, Enable held 1 -> first Window_Valid after the pixel (2,2) is accepted.
  - Window P0..P8 = 0,1,2,8,9,10,16,17,18; Out_Row=1, Out_Column=1.
  - 36 valid windows in total; the last has centre (6,6), P4=54.
- Same frame -> Window_Valid=0 for all of rows 0-1 and for columns 0-1 of every row.
  - At (3,2) the window is 8,9,10,16,17,18,24,25,26.
- Random Enable gaps (1-5 idle cycles) -> identical window sequence to the gap-free run; Window_Valid never asserts during idle cycles.
- Last_In with pixel (7,7) -> Frame_Done=1 for exactly one cycle, together with Window_Valid at centre (6,6).
  - A back-to-back second frame of value 100+8*row+col gives first window 100,101,102,108,109,110,116,117,118.
- Reset=0 asserted at pixel (4,3), asynchronously between edges -> outputs clear before the next edge.
  - After release, a new frame from (0,0) reproduces the first-frame results exactly.
